// File: rtl/digital_io_bank_ctrl.sv
// digital_io_bank_ctrl: processor-side controller for a bank of digital_io pin
// cells. It holds the DIR and OUT registers that drive the cells, and it runs a
// per-pin input path: a 2-flop synchroniser, a debounce counter and a
// rising-edge detector with a sticky flag. The PLC core reaches everything
// through a 4-register bus (DIR, OUT, IN, EDGE). Each access is acknowledged
// one cycle after its strobe.

// Per-pin input path: synchroniser, debounce and sticky rising-edge flag.
module digital_io_pin_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,        // cell data_out, asynchronous to clk
    input  logic dir,        // 1 = pin is an output; its rises are not flagged
    input  logic edge_clr,   // write-1-to-clear request for this pin's flag
    output logic level,      // debounced input level
    output logic edge_flag   // sticky rising-edge flag
);
    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             rise;

    // The new level is accepted on the edge where the run of differing samples
    // reaches DEBOUNCE_CYCLES. A rise is flagged only while the pin is an input.
    always_comb begin
        cnt_inc = cnt + 1'b1;
        accept  = (sync2 != level) && (cnt_inc == DEB);
        rise    = accept && sync2 && !level && !dir;
    end

    // Synchroniser, debounce counter, debounced level and sticky edge flag.
    // When a set and a clear hit the same edge, the set is applied last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt_inc;
            end
            edge_flag <= (edge_flag && !edge_clr) || rise;
        end
    end
endmodule

module digital_io_bank_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       bus_addr,
    input  logic             bus_wr,
    input  logic             bus_rd,
    input  logic [WIDTH-1:0] bus_wdata,
    output logic [WIDTH-1:0] bus_rdata,
    output logic             bus_ack,
    output logic [WIDTH-1:0] pin_en,
    output logic [WIDTH-1:0] pin_dir,
    output logic [WIDTH-1:0] pin_out,
    input  logic [WIDTH-1:0] pin_in,
    output logic             irq
);
    localparam logic [1:0] A_DIR  = 2'd0;
    localparam logic [1:0] A_OUT  = 2'd1;
    localparam logic [1:0] A_IN   = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] in_lvl;
    logic [WIDTH-1:0] edge_flags;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rd_mux;

    assign pin_dir = dir_reg;
    assign pin_out = out_reg;
    assign irq     = |edge_flags;

    // EDGE write-1-to-clear mask, gated by a write to the EDGE address.
    always_comb begin
        edge_clr = '0;
        if (bus_wr && bus_addr == A_EDGE) edge_clr = bus_wdata;
    end

    // Read-data selection from the register values before the strobe edge.
    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            A_DIR:   rd_mux = dir_reg;
            A_OUT:   rd_mux = out_reg;
            A_IN:    rd_mux = in_lvl;
            A_EDGE:  rd_mux = edge_flags;
            default: rd_mux = '0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        digital_io_pin_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .raw      (pin_in[i]),
            .dir      (dir_reg[i]),
            .edge_clr (edge_clr[i]),
            .level    (in_lvl[i]),
            .edge_flag(edge_flags[i])
        );
    end

    // Bus register file, access acknowledge and pin-cell enable.
    // A write takes priority over a read in the same cycle, and the write's ack
    // carries zero data. Reset drops any pending ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_reg   <= '0;
            out_reg   <= '0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            pin_en    <= '0;
        end else begin
            pin_en  <= '1;
            bus_ack <= bus_wr || bus_rd;
            if (bus_wr) begin
                bus_rdata <= '0;
                case (bus_addr)
                    A_DIR:   dir_reg <= bus_wdata;
                    A_OUT:   out_reg <= bus_wdata;
                    default: ;
                endcase
            end else if (bus_rd) begin
                bus_rdata <= rd_mux;
            end else begin
                bus_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_digital_io_bank_ctrl.sv
// Self-checking bench for digital_io_bank_ctrl. The reference model keeps a
// two-deep delay line for the synchroniser and a sliding window of the last
// DEB synchronised samples for debounce. A level is accepted once the whole
// window disagrees with the current debounced level.
module tb_digital_io_bank_ctrl;
    localparam int W   = 8;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   bus_addr;
    logic         bus_wr, bus_rd;
    logic [W-1:0] bus_wdata, bus_rdata;
    logic         bus_ack;
    logic [W-1:0] pin_en, pin_dir, pin_out, pin_in;
    logic         irq;

    digital_io_bank_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .pin_en(pin_en), .pin_dir(pin_dir), .pin_out(pin_out), .pin_in(pin_in), .irq(irq)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    // reference model state
    logic [W-1:0] m_dir, m_out, m_edge, m_in, m_en, m_rdata;
    logic         m_ack;
    logic [W-1:0] sq[$];   // synchroniser delay line: [0] is what sync2 holds
    logic [W-1:0] win[$];  // last DEB synchronised samples

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock edge: advance the model from the pre-edge inputs, then compare.
    task automatic step();
        logic [W-1:0] s, nin, rose, clr, rmux;
        bit           all_diff;
        @(posedge clk);
        if (rst) begin
            m_dir = '0; m_out = '0; m_edge = '0; m_in = '0; m_en = '0;
            m_ack = 1'b0; m_rdata = '0;
            sq = '{W'(0), W'(0)};
            win.delete();
        end else begin
            case (bus_addr)
                2'd0: rmux = m_dir;
                2'd1: rmux = m_out;
                2'd2: rmux = m_in;
                default: rmux = m_edge;
            endcase
            s = sq[0];
            sq.push_back(pin_in);
            void'(sq.pop_front());
            win.push_back(s);
            if (win.size() > DEB) void'(win.pop_front());
            nin = m_in;
            if (win.size() == DEB) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (win[j]) if (win[j][b] == m_in[b]) all_diff = 1'b0;
                    if (all_diff) nin[b] = ~m_in[b];
                end
            end
            rose    = ~m_in & nin & ~m_dir;
            clr     = (bus_wr && bus_addr == 2'd3) ? bus_wdata : '0;
            m_edge  = (m_edge & ~clr) | rose;
            m_ack   = bus_wr | bus_rd;
            m_rdata = bus_wr ? '0 : (bus_rd ? rmux : '0);
            if (bus_wr && bus_addr == 2'd0) m_dir = bus_wdata;
            if (bus_wr && bus_addr == 2'd1) m_out = bus_wdata;
            m_in = nin;
            m_en = '1;
        end
        #1;
        chk("m_pin_en",  pin_en,    m_en);
        chk("m_pin_dir", pin_dir,   m_dir);
        chk("m_pin_out", pin_out,   m_out);
        chk("m_irq",     irq,       |m_edge);
        chk("m_ack",     bus_ack,   m_ack);
        chk("m_rdata",   bus_rdata, m_rdata);
    endtask

    task automatic idle();
        bus_wr = 1'b0; bus_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        bus_wr = 1'b1; bus_rd = 1'b0; bus_addr = a; bus_wdata = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string tag);
        bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = a;
        step();
        idle();
        chk({tag, "_ack"}, bus_ack, 1'b1);
        chk(tag, bus_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; pin_in = '0; bus_addr = 2'd1; bus_wr = 1'b1; bus_rd = 1'b0;
        bus_wdata = 8'hFF;
        sq = '{W'(0), W'(0)};
        // reset has priority over a concurrent write
        step(); step();
        chk("rst_out", pin_out, 8'h00);
        chk("rst_en",  pin_en,  8'h00);
        chk("rst_irq", irq,     1'b0);
        rst = 1'b0; idle();
        step();
        chk("en_after_rst", pin_en, 8'hFF);

        // write / readback
        wr(2'd0, 8'h0F);
        chk("dir_wr", pin_dir, 8'h0F);
        chk("wr_ack", bus_ack, 1'b1);
        wr(2'd1, 8'hA5);
        chk("out_wr", pin_out, 8'hA5);
        rd(2'd0, 8'h0F, "rd_dir");
        rd(2'd1, 8'hA5, "rd_out");
        step();
        chk("ack_pulse", bus_ack, 1'b0);

        // debounce latency: accepted on the 6th edge after the change
        wr(2'd0, 8'h00);
        pin_in = 8'h08;
        repeat (5) step();
        chk("deb_irq_early", irq, 1'b0);
        step();
        chk("deb_irq", irq, 1'b1);
        rd(2'd3, 8'h08, "deb_edge");
        rd(2'd2, 8'h08, "deb_in");
        // short glitch on pin 5 is rejected
        pin_in = 8'h28;
        repeat (3) step();
        pin_in = 8'h08;
        repeat (8) step();
        rd(2'd2, 8'h08, "glitch_in");
        rd(2'd3, 8'h08, "glitch_edge");

        // clear of bit 3 on the same edge pin 0 is accepted
        pin_in = 8'h09;
        repeat (5) step();
        bus_wr = 1'b1; bus_addr = 2'd3; bus_wdata = 8'h08;
        step(); idle();
        chk("race_irq", irq, 1'b1);
        rd(2'd3, 8'h01, "race_edge");
        wr(2'd3, 8'h01);
        chk("clr_irq", irq, 1'b0);

        // output-mode pins follow on IN but never flag edges
        wr(2'd0, 8'hFF);
        pin_in = 8'hF0;
        repeat (8) step();
        rd(2'd2, 8'hF0, "outpin_in");
        rd(2'd3, 8'h00, "outpin_edge");

        // simultaneous strobes: write wins, single ack with zero data
        bus_wr = 1'b1; bus_rd = 1'b1; bus_addr = 2'd1; bus_wdata = 8'h3C;
        step(); idle();
        chk("both_out",   pin_out,   8'h3C);
        chk("both_ack",   bus_ack,   1'b1);
        chk("both_rdata", bus_rdata, 8'h00);
        step();
        chk("both_single", bus_ack, 1'b0);

        // reset on the cycle a read ack is showing drops it afterwards
        bus_rd = 1'b1; bus_addr = 2'd0;
        step();
        idle(); rst = 1'b1;
        step();
        chk("rst_drop_ack", bus_ack, 1'b0);
        rst = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            bus_wr    = ($urandom_range(0, 3) == 0);
            bus_rd    = ($urandom_range(0, 3) == 0);
            bus_addr  = 2'($urandom_range(0, 3));
            bus_wdata = W'($urandom);
            pin_in    = pin_in ^ W'($urandom & $urandom & $urandom);
            step();
            if (bus_ack === 1'b1 && m_ack && !rst) chk("rnd_ack_seen", bus_ack, m_ack);
        end
        rst = 1'b0; idle();
        step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/digital_io_bank_ctrl.md
Name: digital_io_bank_ctrl

Overview:
- Processor-side controller for a bank of WIDTH digital_io pin cells. It drives each cell's en, direction and data_in, and receives each cell's data_out.
- Exposes a 4-register bus interface to the PLC core: DIR, OUT, IN and EDGE.
- Input path per pin: 2-flop synchroniser, then debounce counter, then rising-edge detector with a sticky flag and an interrupt.
- All logic runs on the rising edge of clk. The pin cells sample and drive on the falling edge.

Parameters:
- WIDTH, 8, number of pins in the bank.
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples required to accept a new input level (range 1..255).
- CNT_W, 8, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- bus_addr  input  2  register select: 0=DIR, 1=OUT, 2=IN, 3=EDGE.
- bus_wr  input  1  write strobe, one-cycle pulse.
- bus_rd  input  1  read strobe, one-cycle pulse.
- bus_wdata  input  WIDTH  write data.
- bus_rdata  output  WIDTH  read data, valid while bus_ack=1.
- bus_ack  output  1  access complete, one-cycle pulse.
- pin_en  output  WIDTH  to each cell's en.
- pin_dir  output  WIDTH  to each cell's direction (1=output).
- pin_out  output  WIDTH  to each cell's data_in.
- pin_in  input  WIDTH  from each cell's data_out. Asynchronous to this block's sampling.
- irq  output  1  OR of all EDGE bits.

Behaviour:
- Reset (clk edge with rst=1): DIR=0 (all inputs), OUT=0, EDGE=0, debounced IN=0, sync flops=0, debounce counters=0, bus_ack=0, bus_rdata=0, pin_en=0. rst has priority over every bus access in the same cycle.
- pin_en is registered. It is 0 during reset and goes all-ones on the first edge after rst deasserts.
- pin_dir=DIR and pin_out=OUT are driven directly from the registers.
- Bus write (bus_wr=1 at a clk edge):
  - addr 0: DIR <= bus_wdata.
  - addr 1: OUT <= bus_wdata.
  - addr 2: write ignored.
  - addr 3: write-1-to-clear on EDGE.
  - bus_ack=1 on the following cycle, bus_rdata=0.
- Bus read (bus_rd=1): on the next cycle bus_ack=1 and bus_rdata holds the register value sampled at the strobe edge. Register map: DIR, OUT, debounced IN, EDGE.
- bus_rd and bus_wr together: the write is performed, the read is discarded, and a single ack is issued.
- Strobes held high for multiple cycles produce one access and one ack per cycle.
- Synchroniser: sync1 <= pin_in; sync2 <= sync1.
- Debounce, per pin:
  - If sync2 == IN[i], the counter clears.
  - Otherwise the counter increments.
  - When the incremented value equals DEBOUNCE_CYCLES: IN[i] <= sync2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised samples never changes IN.
  - Latency: a clean step on pin_in appears in IN at the (2+DEBOUNCE_CYCLES)th rising edge after the change, i.e. the 6th edge with defaults.
- IN reflects pin readback for every pin, including pins in output mode.
- Edge detect: EDGE[i] is set on the same edge that IN[i] goes 0->1, only when DIR[i]=0. Falling transitions and output-mode pins never set EDGE.
- EDGE is sticky until cleared. If a set and a write-1-clear hit the same bit on the same edge, the set wins and the bit stays 1.
- irq is combinational OR of EDGE.
- Changing DIR[i] from 1 to 0 does not clear EDGE[i] or the debounce state.
- Reset mid-access: a pending ack is dropped, so bus_ack=0 on the cycle after the reset edge.

Test Plan:
- Reset: assert rst for 2 cycles with bus_wr=1, addr 1, wdata 8'hFF -> OUT=0, pin_en=0, irq=0. After release, pin_en=8'hFF on the next edge.
- Write/readback: write DIR=8'h0F, then OUT=8'hA5, then read addr 0 and addr 1 -> pin_dir=8'h0F, pin_out=8'hA5, bus_rdata 8'h0F then 8'hA5, each with a one-cycle bus_ack one cycle after the strobe.
- Debounce latency: DIR=0, drive pin_in[3] 0->1 -> IN bit 3 rises exactly 6 edges later, EDGE=8'h08, irq=1. A 3-cycle pulse on pin_in[5] -> IN and EDGE unchanged.
- EDGE clear race: EDGE=8'h08, write addr 3 wdata 8'h08 on the same edge that pin 0 is accepted high -> EDGE=8'h01, irq stays 1. A second clear with 8'h01 -> EDGE=0, irq=0.
- Output pins: DIR=8'hFF, pin_in toggles 0->1 stable -> IN follows after 6 edges, EDGE stays 0.
- Simultaneous strobes: bus_rd=bus_wr=1, addr 1, wdata 8'h3C -> OUT=8'h3C, exactly one ack, bus_rdata=0.
